// File: rtl/wb_fpga_regbank.sv
// wb_fpga_regbank: Wishbone slave register bank with ID/REV constants,
// synchronised status inputs, a W1C interrupt status register with enable
// mask, and NUM_SCRATCH read/write scratch registers.
// Define WB_REGBANK_CHG_CNT_EN to build the 16-bit status change counter at
// offset 0x014. Without it, that offset reads DEF_REG_VALUE and ignores writes.
`default_nettype none

module wb_fpga_regbank #(
    parameter int          ADDRWIDTH     = 10,
    parameter int          DATAWIDTH     = 32,
    parameter int          NUM_SCRATCH   = 4,
    parameter int          ACK_WAIT      = 0,
    parameter int          STAT_WIDTH    = 4,
    parameter logic [31:0] DEVICE_ID     = 32'h0,
    parameter logic [31:0] REV_LEVEL     = 32'h0,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]  WBs_DAT_i,
    output logic [DATAWIDTH-1:0]  WBs_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [STAT_WIDTH-1:0] stat_i,
    output logic                  int_o,
    output logic [DATAWIDTH-1:0]  ctrl_o,
    output logic [31:0]           Device_ID_o
);

    localparam int AW = ADDRWIDTH - 2;

    // Word indices of the fixed registers.
    localparam logic [AW-1:0] W_ID       = AW'(0);
    localparam logic [AW-1:0] W_REV      = AW'(1);
    localparam logic [AW-1:0] W_STATUS   = AW'(2);
    localparam logic [AW-1:0] W_INT_STAT = AW'(3);
    localparam logic [AW-1:0] W_INT_EN   = AW'(4);
`ifdef WB_REGBANK_CHG_CNT_EN
    localparam logic [AW-1:0] W_CHG_CNT  = AW'(5);
`endif
    // Scratch window occupies word indices 8..15 (byte offsets 0x020..0x03C).
    localparam logic [AW-4:0] SCR_HI     = (AW-3)'(1);
    localparam logic [1:0]    ACK_WAIT_C = 2'(ACK_WAIT);

    logic [AW-1:0]          adr_w;
    logic [2:0]             scr_idx;
    logic                   scr_region;
    logic                   xfer;
    logic                   ack_set;
    logic                   wr_en;
    logic                   ack_q, ack_d;
    logic [1:0]             wait_q, wait_d;
    logic [DATAWIDTH-1:0]   be_mask;
    logic [DATAWIDTH-1:0]   scratch_q [NUM_SCRATCH];
    logic [STAT_WIDTH-1:0]  sync1_q, sync2_q, prev_q, chg;
    logic [STAT_WIDTH-1:0]  st_mask, st_wdata;
    logic [STAT_WIDTH-1:0]  int_stat_q, int_stat_d;
    logic [STAT_WIDTH-1:0]  int_en_q, int_en_d;
    logic                   int_q, int_d;
    logic                   unused_adr_bits;

    assign adr_w           = WBs_ADR_i[ADDRWIDTH-1:2];
    assign scr_idx         = adr_w[2:0];
    assign scr_region      = (adr_w[AW-1:3] == SCR_HI);
    assign unused_adr_bits = ^WBs_ADR_i[1:0];

    // Expand the four byte strobes into a per-bit write mask.
    for (genvar k = 0; k < DATAWIDTH; k++) begin : g_be_mask
        assign be_mask[k] = WBs_BYTE_STB_i[(k/8) % 4];
    end

    // A transfer is live while the master requests and the current one is not yet acknowledged.
    assign xfer    = WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign ack_set = xfer & (wait_q == ACK_WAIT_C);
    assign wr_en   = ack_set & WBs_WE_i;

    // Next state of the wait counter and acknowledge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ack_d  = ack_set;
        wait_d = 2'd0;
        if (xfer && !ack_set) begin
            wait_d = wait_q + 2'd1;
        end
    end

    // Handshake state: dropping CYC/STB or reset clears the counter and suppresses ACK.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            ack_q  <= 1'b0;
            wait_q <= 2'd0;
        end else begin
            ack_q  <= ack_d;
            wait_q <= wait_d;
        end
    end

    // Scratch registers: byte-lane merge on the edge that raises ACK.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            // NOTE: this small register array is reset explicitly because software relies on it reading 0.
            for (int n = 0; n < NUM_SCRATCH; n++) begin
                scratch_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_SCRATCH; n++) begin
                if (wr_en && scr_region && scr_idx == 3'(n)) begin
                    scratch_q[n] <= (scratch_q[n] & ~be_mask) | (WBs_DAT_i & be_mask);
                end
            end
        end
    end

    // Two-flop synchroniser followed by the "prev" register used for edge detection.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= stat_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign chg      = sync2_q ^ prev_q;
    assign st_mask  = be_mask[STAT_WIDTH-1:0];
    assign st_wdata = WBs_DAT_i[STAT_WIDTH-1:0];

    // Interrupt status (W1C, a new change beats a coincident clear) and enable mask.
    always_comb begin
        int_stat_d = int_stat_q;
        int_en_d   = int_en_q;
        if (wr_en && adr_w == W_INT_STAT) begin
            int_stat_d = int_stat_q & ~(st_wdata & st_mask);
        end
        int_stat_d = int_stat_d | chg;
        if (wr_en && adr_w == W_INT_EN) begin
            int_en_d = (int_en_q & ~st_mask) | (st_wdata & st_mask);
        end
        int_d = |(int_stat_q & int_en_q);
    end

    // Interrupt registers; int_o follows its operands by one cycle.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            int_stat_q <= '0;
            int_en_q   <= '0;
            int_q      <= 1'b0;
        end else begin
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            int_q      <= int_d;
        end
    end

`ifdef WB_REGBANK_CHG_CNT_EN
    logic [15:0] chg_cnt_q, chg_cnt_d;

    // Change counter: software clear takes priority over a coincident increment.
    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (wr_en && adr_w == W_CHG_CNT && WBs_BYTE_STB_i[0]) begin
            chg_cnt_d = 16'd0;
        end else if (|chg && chg_cnt_q != 16'hFFFF) begin
            chg_cnt_d = chg_cnt_q + 16'd1;
        end
    end

    // Change counter register, saturating at 16'hFFFF.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            chg_cnt_q <= 16'd0;
        end else begin
            chg_cnt_q <= chg_cnt_d;
        end
    end
`endif

    // Read mux, purely combinational from the address; unmapped words return DEF_REG_VALUE.
    always_comb begin
        WBs_DAT_o = DATAWIDTH'(DEF_REG_VALUE);
        case (adr_w)
            W_ID:       WBs_DAT_o = DATAWIDTH'(DEVICE_ID);
            W_REV:      WBs_DAT_o = DATAWIDTH'(REV_LEVEL);
            W_STATUS:   WBs_DAT_o = DATAWIDTH'(sync2_q);
            W_INT_STAT: WBs_DAT_o = DATAWIDTH'(int_stat_q);
            W_INT_EN:   WBs_DAT_o = DATAWIDTH'(int_en_q);
`ifdef WB_REGBANK_CHG_CNT_EN
            W_CHG_CNT:  WBs_DAT_o = DATAWIDTH'(chg_cnt_q);
`endif
            default:    ;
        endcase
        if (scr_region) begin
            for (int n = 0; n < NUM_SCRATCH; n++) begin
                if (scr_idx == 3'(n)) begin
                    WBs_DAT_o = scratch_q[n];
                end
            end
        end
    end

    assign WBs_ACK_o   = ack_q;
    assign int_o       = int_q;
    assign ctrl_o      = scratch_q[0];
    assign Device_ID_o = DEVICE_ID;

endmodule

`default_nettype wire

// File: doc/wb_fpga_regbank.md
WB_FPGA_REGBANK -- requirements
Module: wb_fpga_regbank

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDRWIDTH, 10, Wishbone byte-address width.
- DATAWIDTH, 32, data bus width.
- NUM_SCRATCH, 4, number of read/write scratch registers (1..8).
- ACK_WAIT, 0, wait cycles inserted before ACK (0..3).
- STAT_WIDTH, 4, number of status inputs (1..16).
- DEVICE_ID, 32'h0, ID register value.
- REV_LEVEL, 32'h0, revision register value.
- DEF_REG_VALUE, 32'hFAB_DEF_AC, read value of unmapped addresses.
REQ-002 Ports, one per line (name, direction, width, meaning):
- WBs_CLK_i, in, 1, clock.
- WBs_RST_i, in, 1, reset; asynchronous, active-high.
- WBs_ADR_i, in, ADDRWIDTH, byte address.
- WBs_CYC_i, in, 1, cycle select.
- WBs_STB_i, in, 1, strobe.
- WBs_WE_i, in, 1, write enable.
- WBs_BYTE_STB_i, in, 4, byte lane enables.
- WBs_DAT_i, in, DATAWIDTH, write data.
- WBs_DAT_o, out, DATAWIDTH, read data.
- WBs_ACK_o, out, 1, acknowledge.
- stat_i, in, STAT_WIDTH, asynchronous status inputs.
- int_o, out, 1, interrupt.
- ctrl_o, out, DATAWIDTH, contents of scratch register 0.
- Device_ID_o, out, 32, constant DEVICE_ID.

Function
REQ-003 Decode on word index WBs_ADR_i[ADDRWIDTH-1:2] (byte offsets):
- 0x000 ID (RO).
- 0x004 REV (RO).
- 0x008 STATUS (RO; synchronised stat_i, zero-extended).
- 0x00C INT_STAT (W1C).
- 0x010 INT_EN (RW, STAT_WIDTH bits).
- 0x014 CHG_CNT (RO, 16 bits).
- 0x020+4n scratch n, for n < NUM_SCRATCH.
REQ-004 Reads of unmapped offsets, or of scratch indices >= NUM_SCRATCH, SHALL return DEF_REG_VALUE; writes to them SHALL be ignored.
REQ-005 WBs_DAT_o SHALL be combinational from the address; unused upper bits read 0.
REQ-006 A wait counter SHALL count cycles while CYC&STB&!ACK; WBs_ACK_o SHALL pulse high for exactly one cycle, ACK_WAIT+1 cycles after CYC&STB first sample high.
REQ-007 If CYC or STB drops before ACK, the counter SHALL clear, no ACK SHALL issue, and no register SHALL change.
REQ-008 Writes SHALL take effect at the clock edge that raises ACK.
REQ-009 Only byte lanes with WBs_BYTE_STB_i[k]=1 SHALL update; a write with all strobes 0 SHALL change nothing.
REQ-010 stat_i SHALL pass through a 2-flop synchroniser, then a "prev" register; change = sync XOR prev.
REQ-011 INT_STAT bit i SHALL set on change[i] and SHALL clear when 1 is written to it in an enabled lane; if set and clear coincide, set SHALL win.
REQ-012 int_o SHALL be registered: |(INT_STAT & INT_EN), one cycle after either operand changes.
REQ-013 CHG_CNT SHALL increment by 1 in each cycle where any change bit is 1 and SHALL saturate at 16'hFFFF.
REQ-014 A write to CHG_CNT with BYTE_STB[0]=1 SHALL clear it; if clear and increment coincide, clear SHALL win.

Reset
REQ-015 On WBs_RST_i the following SHALL be 0: ACK, wait counter, scratch, INT_EN, INT_STAT, CHG_CNT, synchroniser, prev, int_o.
REQ-016 A nonzero stat_i at reset release SHALL be flagged as a change 2 cycles after release.
REQ-017 Reset asserted mid-transfer SHALL abort it, with no ACK and no write.

Configuration
REQ-018 Macro WB_REGBANK_CHG_CNT_EN defined: CHG_CNT is implemented per REQ-013/014. Undefined: no counter logic; offset 0x014 behaves as unmapped (reads DEF_REG_VALUE, writes ignored).

Verification
REQ-019 ACK_WAIT=2, read 0x000, DEVICE_ID=32'hA5A5_0001 -> ACK on 3rd cycle after STB, one cycle wide, data 32'hA5A5_0001.
REQ-020 Write 32'h11223344 to 0x020 with BYTE_STB=4'b0101, prior value 0 -> reads 32'h00220044; ctrl_o=32'h00220044.
REQ-021 stat_i 0->4'b0010, INT_EN=4'b0010 -> INT_STAT=0x2 and int_o=1; write 0x2 to 0x00C -> INT_STAT=0, int_o=0 next cycle; a change in the same cycle as the clear keeps bit set.
REQ-022 STB dropped after 1 cycle with ACK_WAIT=3 on a write to 0x024 -> no ACK, scratch1 unchanged; read of 0x03C with NUM_SCRATCH=4 -> 32'hFABDEFAC.
REQ-023 With WB_REGBANK_CHG_CNT_EN, 3 toggles of stat_i -> CHG_CNT=3, clear write -> 0; without the macro, read 0x014 -> 32'hFABDEFAC.
